spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front end: deserialises MOSI frames into 10-bit command words for the single-port RAM.
//  Each word is presented as rx_data/rx_valid; RAM decodes rx_data[9:8]: 00 wr addr, 01 wr data, 10 rd addr, 11 rd data.
//  For read-data frames, waits for the RAM's tx_data/tx_valid and shifts the byte out on MISO, MSB first.
// PARAMETERS
//  DATA_W  8  RAM data width; command word width = DATA_W+2
// PORTS
//  clk       in   1         clock, all logic on rising edge
//  rst_n     in   1         reset, synchronous, active-low
//  ss_n      in   1         slave select, active-low; high aborts frame
//  mosi      in   1         serial in, sampled every clk while ss_n=0
//  tx_data   in   DATA_W    read byte from RAM
//  tx_valid  in   1         tx_data valid (1-cycle pulse from RAM)
//  miso      out  1         serial out, registered
//  rx_data   out  DATA_W+2  command word to RAM
//  rx_valid  out  1         1-cycle pulse, rx_data valid
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, miso=0, rx_data=0, rx_valid=0.
//    Also cleared: bit counter, shift regs, rd_addr_seen flag. rst_n wins over all inputs.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//   IDLE: ss_n=0 -> CHK_CMD. mosi ignored.
//   CHK_CMD: ss_n=1 -> IDLE; else sample mosi as word bit 9 into shift reg.
//     Next state: mosi=0 -> WRITE; mosi=1 & rd_addr_seen=0 -> READ_ADD; mosi=1 & rd_addr_seen=1 -> READ_DATA.
//   WRITE/READ_ADD/READ_DATA: shift mosi MSB-first for remaining 9 bits (bits 8..0), one per clk.
//    On edge sampling bit 0: rx_data<={shift[8:0],mosi}, rx_valid<=1 for exactly one cycle.
//    Word forwarded verbatim; FSM never alters bits [9:8].
//    After the word, further mosi bits ignored; no second rx_valid in the same frame.
//   READ_ADD: on word completion rd_addr_seen<=1; hold until ss_n=1.
//   READ_DATA: after word, wait for tx_valid=1 (any number of cycles; RAM gives 1 cycle later).
//    Edge sampling tx_valid=1: miso<=tx_data[7], remaining 7 bits latched.
//    Next 7 edges shift out bits 6..0; each miso bit held 1 cycle, 8 cycles total.
//    rd_addr_seen<=0 when tx_valid is captured. miso=0 after last bit until ss_n=1.
//    tx_valid outside READ_DATA-after-word is ignored.
//  miso=0 in all states except the 8-bit output window.
//  ss_n=1 in any non-IDLE state -> IDLE next edge.
//    Counters and shift regs cleared; partial word discarded (no rx_valid).
//    miso<=0, output window aborted; rd_addr_seen keeps its value.
//  ss_n=1 on the edge sampling bit 0: frame aborted, no rx_valid.
//  ss_n low->high->low gap min 1 cycle in IDLE before the next CHK_CMD.
//  Latency: rx_valid 11 clks after first ss_n=0 edge.
//    First miso bit 1 clk after tx_valid.
// TESTING
//  Reset: assert rst_n=0 with ss_n=0, mosi=1 -> miso=0, rx_valid=0, rx_data=0; next frame decodes as READ_ADD.
//  Write addr: ss_n=0, mosi 00_1010_0101 -> single rx_valid with rx_data=10'h0A5 at clk 11; miso=0.
//    Then 01_0011_1100 -> rx_data=10'h13C.
//  Read sequence: send 10_1010_0101 (READ_ADD, flag=1), ss_n=1.
//    Then 11_0000_0000 -> rx_valid rx_data=10'h300; model tx_valid next cycle with tx_data=8'hC3.
//    miso=1,1,0,0,0,0,1,1 over 8 clks; next frame with bit9=1 goes to READ_ADD.
//  Abort: ss_n=1 after 5 bits -> no rx_valid, state IDLE next clk.
//    Following full frame 00_0000_0001 -> rx_data=10'h001.
//  Late tx_valid: READ_DATA, hold tx_valid=0 for 4 clks, then pulse with 8'h5A -> miso 0,1,0,1,1,0,1,0.
//    Extra mosi toggling ignored, no extra rx_valid.
//  Abort during output: ss_n=1 after 3 miso bits -> miso=0 next clk; rd_addr_seen already 0.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-side command/read-byte signals of the SPI slave front end.
// master = SPI master + RAM environment, slave = spi_slave_if.
interface spi_slave_if_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises MOSI into DATA_W+2 command words (rx_valid 11 clks after frame start),
// shifts the RAM read byte out on MISO 1 clk after tx_valid; no backpressure, RAM must take every pulse.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_if_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int OUT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W:0]     shift_q, shift_d;
  logic                word_done_q, word_done_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_W-2:0]   tx_sh_q, tx_sh_d;
  logic [OUT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_done_q, tx_done_d;
  logic                miso_q, miso_d;
  logic [DATA_W+1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                abort;

  assign abort = bus.ss_n && (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    word_done_d    = word_done_q;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_sh_d        = tx_sh_q;
    out_cnt_d      = out_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;

    if (abort) begin
      // Partial word and output window are dropped; rd_addr_seen survives the abort.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      word_done_d = 1'b0;
      tx_sh_d     = '0;
      out_cnt_d   = '0;
      tx_busy_d   = 1'b0;
      tx_done_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.ss_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          shift_d   = {{DATA_W{1'b0}}, bus.mosi};
          bit_cnt_d = CNT_W'(DATA_W);
          if (!bus.mosi)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                    state_d = READ_ADD;
        end
        default: begin
          if (!word_done_q) begin
            if (bit_cnt_q == '0) begin
              rx_data_d   = {shift_q, bus.mosi};
              rx_valid_d  = 1'b1;
              word_done_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end else begin
              shift_d   = {shift_q[DATA_W-1:0], bus.mosi};
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (out_cnt_q != '0) begin
                miso_d    = tx_sh_q[DATA_W-2];
                tx_sh_d   = tx_sh_q << 1;
                out_cnt_d = out_cnt_q - OUT_W'(1);
              end else begin
                tx_busy_d = 1'b0;
                tx_done_d = 1'b1;
              end
            end else if (!tx_done_q && bus.tx_valid) begin
              // Only one byte per read frame; later tx_valid pulses are ignored.
              miso_d         = bus.tx_data[DATA_W-1];
              tx_sh_d        = bus.tx_data[DATA_W-2:0];
              out_cnt_d      = OUT_W'(DATA_W - 1);
              tx_busy_d      = 1'b1;
              rd_addr_seen_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      word_done_q    <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_sh_q        <= '0;
      out_cnt_q      <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      word_done_q    <= word_done_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_sh_q        <= tx_sh_d;
      out_cnt_q      <= out_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: command frames, read-byte output, aborts and reset.
module tb_spi_slave_if;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   rxv_cnt;
  logic miso_seen;
  logic [7:0] got;
  int   base;

  spi_slave_if_if #(.DATA_W(8)) bus ();

  spi_slave_if #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.rx_valid === 1'b1) rxv_cnt++;
    if (bus.miso === 1'b1) miso_seen = 1'b1;
  endtask

  task automatic send_frame(input logic [9:0] w, input int nbits);
    bus.ss_n = 1'b0;
    tick();
    for (int i = 9; i >= 10 - nbits; i--) begin
      bus.mosi = w[i];
      if (i == 0) chk("rxv_early", {31'b0, bus.rx_valid}, 32'd0);
      tick();
    end
    if (nbits == 10) begin
      chk("rxv_pulse", {31'b0, bus.rx_valid}, 32'd1);
      chk("rx_data", {22'b0, bus.rx_data}, {22'b0, w});
    end
  endtask

  task automatic end_frame();
    bus.ss_n = 1'b1;
    tick();
  endtask

  task automatic read_out(input int dly, input logic [7:0] d, output logic [7:0] obs);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      bus.mosi = ~bus.mosi;
      tick();
      chk("miso_wait", {31'b0, bus.miso}, 32'd0);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    bus.mosi     = ~bus.mosi;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    obs[7] = bus.miso;
    for (int i = 6; i >= 0; i--) begin
      bus.mosi = ~bus.mosi;
      tick();
      obs[i] = bus.miso;
    end
    bus.mosi = ~bus.mosi;
    tick();
    chk("miso_tail", {31'b0, bus.miso}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rxv_cnt = 0;
    miso_seen = 1'b0;
    rst_n = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    chk("rst_miso", {31'b0, bus.miso}, 32'd0);
    chk("rst_rxv", {31'b0, bus.rx_valid}, 32'd0);
    chk("rst_rxd", {22'b0, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write address then write data.
    base = rxv_cnt;
    miso_seen = 1'b0;
    send_frame(10'h0A5, 10);
    repeat (3) begin bus.mosi = ~bus.mosi; tick(); end
    end_frame();
    chk("wr_addr_cnt", rxv_cnt - base, 1);
    chk("wr_miso", {31'b0, miso_seen}, 32'd0);
    send_frame(10'h13C, 10);
    end_frame();
    chk("wr_data_cnt", rxv_cnt - base, 2);

    // Read address, then read data with tx_valid one cycle later.
    send_frame(10'h2A5, 10);
    end_frame();
    send_frame(10'h300, 10);
    read_out(0, 8'hC3, got);
    chk("rd_byte_c3", {24'b0, got}, 32'h0C3);
    end_frame();

    // Flag cleared by the read: next bit9=1 frame is a read address, no output.
    send_frame(10'h3FF, 10);
    read_out(0, 8'hFF, got);
    chk("rd_add_after_rd", {24'b0, got}, 32'h000);
    end_frame();

    // Abort after 5 bits, then a complete frame.
    base = rxv_cnt;
    send_frame(10'h155, 5);
    end_frame();
    chk("abort_no_rxv", rxv_cnt - base, 0);
    send_frame(10'h001, 10);
    end_frame();
    chk("after_abort_cnt", rxv_cnt - base, 1);

    // Late tx_valid (flag still set from the 3FF read-address frame).
    base = rxv_cnt;
    send_frame(10'h3AA, 10);
    read_out(4, 8'h5A, got);
    chk("rd_byte_5a", {24'b0, got}, 32'h05A);
    repeat (3) begin bus.mosi = ~bus.mosi; tick(); end
    end_frame();
    chk("late_rxv_cnt", rxv_cnt - base, 1);

    // Abort during the output window.
    send_frame(10'h2F0, 10);
    end_frame();
    send_frame(10'h3C0, 10);
    bus.tx_data = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("abort_out_b7", {31'b0, bus.miso}, 32'd1);
    tick();
    tick();
    chk("abort_out_b5", {31'b0, bus.miso}, 32'd1);
    bus.ss_n = 1'b1;
    tick();
    chk("abort_out_miso", {31'b0, bus.miso}, 32'd0);
    tick();
    chk("abort_out_idle", {31'b0, bus.miso}, 32'd0);
    send_frame(10'h3FF, 10);
    read_out(0, 8'hFF, got);
    chk("abort_out_flag", {24'b0, got}, 32'h000);
    end_frame();

    // Reset during an output window.
    send_frame(10'h3A5, 10);
    bus.tx_data = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    tick();
    chk("pre_rst_miso", {31'b0, bus.miso}, 32'd1);
    rst_n = 1'b0;
    bus.ss_n = 1'b0;
    bus.mosi = 1'b1;
    tick();
    chk("rst2_miso", {31'b0, bus.miso}, 32'd0);
    chk("rst2_rxv", {31'b0, bus.rx_valid}, 32'd0);
    chk("rst2_rxd", {22'b0, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    bus.ss_n = 1'b1;
    tick();

    // Reset clears rd_addr_seen: set it, reset, next bit9=1 frame is a read address.
    send_frame(10'h2A5, 10);
    rst_n = 1'b0;
    bus.ss_n = 1'b0;
    bus.mosi = 1'b1;
    tick();
    tick();
    chk("rst3_rxd", {22'b0, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    bus.ss_n = 1'b1;
    tick();
    send_frame(10'h3FF, 10);
    read_out(0, 8'hFF, got);
    chk("rst_flag_clr", {24'b0, got}, 32'h000);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
